// File: rtl/aes_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes_pkg : key-size codes, round counts, FSM encodings, AES byte helpers  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package aes_pkg;

  localparam logic [3:0] NK_AES128 = 4'd3;
  localparam logic [3:0] NK_AES192 = 4'd5;
  localparam logic [3:0] NK_AES256 = 4'd7;

  localparam logic [3:0] NR_AES128 = 4'd10;
  localparam logic [3:0] NR_AES192 = 4'd12;
  localparam logic [3:0] NR_AES256 = 4'd14;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_ROUND = 3'd2;
  localparam logic [2:0] ST_FINAL = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = xtime(sh);
    end
    return acc;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Byte n of the block is row n%4, column n/4; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        r[127 - 8*(4*c + row) -: 8] = s[127 - 8*(4*((c + row) % 4) + row) -: 8];
    return r;
  endfunction

  function automatic logic [3:0] nr_of(input logic [3:0] nk);
    case (nk)
      NK_AES128: return NR_AES128;
      NK_AES192: return NR_AES192;
      NK_AES256: return NR_AES256;
      default:   return 4'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_encipher_core_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes_encipher_core_if : host block interface of the AES encipher core     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface aes_encipher_core_if;
  logic [3:0]   nk;
  logic         start;
  logic [127:0] block_in;
  logic         busy;
  logic         done;
  logic [127:0] block_out;
  logic         cfg_err;

  modport master (output nk, start, block_in, input busy, done, block_out, cfg_err);
  modport slave  (input nk, start, block_in, output busy, done, block_out, cfg_err);
endinterface
`default_nettype wire

// File: rtl/aes_enc_round.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes_enc_round : SubBytes + ShiftRows + optional MixColumns + AddRoundKey |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module aes_enc_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] round_key_i,
  input  logic         final_round_i,
  output logic [127:0] state_o
);

  // S-box as GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] aes_sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [127:0] sub_bytes;
  logic [127:0] shifted;
  logic [127:0] mixed;

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    assign sub_bytes[8*i +: 8] = aes_sbox(state_i[8*i +: 8]);
  end

  assign shifted = shift_rows(sub_bytes);

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mixed[32*c +: 32] = mix_column(shifted[32*c +: 32]);
  end

  assign state_o = (final_round_i ? shifted : mixed) ^ round_key_i;

endmodule
`default_nettype wire

// File: rtl/aes_encipher_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes_encipher_core : iterative AES-128/192/256 encipher, one round/clock  |
// | Option macro AES_ENC_KEY_CHECK_EN: stall while ex_key valid bit is low.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module aes_encipher_core
  import aes_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  aes_encipher_core_if.slave  host,
  output logic [3:0]          key_addr_o,
  input  logic [128:0]        ex_key_i,
  output logic                key_wait_o
);

  logic [2:0]   fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] block_out_q, block_out_d;
  logic [3:0]   nr_q, nr_d;
  logic [3:0]   ctr_q, ctr_d;
  logic         cfg_err_q, cfg_err_d;
  logic         active;
  logic         stall;
  logic [127:0] round_out;

  assign active = (fsm_q == ST_INIT) || (fsm_q == ST_ROUND) || (fsm_q == ST_FINAL);

`ifdef AES_ENC_KEY_CHECK_EN
  assign stall = active && !ex_key_i[128];
`else
  logic unused_key_valid;
  assign unused_key_valid = ex_key_i[128];
  assign stall = 1'b0;
`endif

  aes_enc_round u_round (
    .state_i       (state_q),
    .round_key_i   (ex_key_i[127:0]),
    .final_round_i (fsm_q == ST_FINAL),
    .state_o       (round_out)
  );

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    block_out_d = block_out_q;
    nr_d        = nr_q;
    ctr_d       = ctr_q;
    cfg_err_d   = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        if (host.start) begin
          if (nr_of(host.nk) != 4'd0) begin
            state_d = host.block_in;
            nr_d    = nr_of(host.nk);
            ctr_d   = 4'd0;
            fsm_d   = ST_INIT;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_INIT: begin
        if (!stall) begin
          state_d = state_q ^ ex_key_i[127:0];
          ctr_d   = 4'd1;
          fsm_d   = ST_ROUND;
        end
      end
      ST_ROUND: begin
        if (!stall) begin
          state_d = round_out;
          ctr_d   = ctr_q + 4'd1;
          if (ctr_q == nr_q - 4'd1) fsm_d = ST_FINAL;
        end
      end
      ST_FINAL: begin
        if (!stall) begin
          state_d     = round_out;
          block_out_d = round_out;
          fsm_d       = ST_DONE;
        end
      end
      ST_DONE: fsm_d = ST_IDLE;
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= ST_IDLE;
      state_q     <= '0;
      block_out_q <= '0;
      nr_q        <= '0;
      ctr_q       <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      block_out_q <= block_out_d;
      nr_q        <= nr_d;
      ctr_q       <= ctr_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign host.busy      = active;
  assign host.done      = (fsm_q == ST_DONE);
  assign host.block_out = block_out_q;
  assign host.cfg_err   = cfg_err_q;
  assign key_addr_o     = active ? ctr_q : 4'd0;
  assign key_wait_o     = stall;

endmodule
`default_nettype wire

// File: tb/tb_aes_encipher_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_aes_encipher_core : randomized bench with a byte-level AES model      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_aes_encipher_core;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   key_addr;
  logic [128:0] ex_key;
  logic         key_wait;
  logic         key_valid;
  logic [127:0] rk [0:14];
  int           n_checks = 0;
  int           n_fail = 0;

  aes_encipher_core_if host_if ();

  aes_encipher_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .host       (host_if),
    .key_addr_o (key_addr),
    .ex_key_i   (ex_key),
    .key_wait_o (key_wait)
  );

  // The bench plays the key-expansion block: combinational round-key lookup.
  assign ex_key = {key_valid, rk[key_addr]};

  always #5 clk = ~clk;

  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX_TBL[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 0; aa = a; bb = b;
    while (bb != 0) begin
      if (bb[0]) p = p ^ aa;
      aa = (aa[7]) ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // FIPS-197 key schedule; key is left-justified, nk counts 32-bit words.
  task automatic expand_key(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0]  rcon;
    int nr;
    nr = nk + 6;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr + 1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = {sb(tmp[23:16]), sb(tmp[15:8]), sb(tmp[7:0]), sb(tmp[31:24])} ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = {sb(tmp[31:24]), sb(tmp[23:16]), sb(tmp[15:8]), sb(tmp[7:0])};
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int r = 0; r < 15; r++)
      rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : {4{$urandom}};
  endtask

  function automatic logic [127:0] ref_cipher(input logic [127:0] pt, input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] out;
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ rk[0][127 - 8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb(s[i]);
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[row + 4*c] = t[row + 4*((c + row) % 4)];
      if (r != nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
          s[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[r][127 - 8*i -: 8];
    end
    for (int i = 0; i < 16; i++) out[127 - 8*i -: 8] = s[i];
    return out;
  endfunction

  // Runs one block; lat = cycles after the start-sampling edge at which done is seen.
  task automatic run_block(input logic [3:0] nk, input logic [127:0] pt, input int stall_at,
                           input int stall_len, input int poke_at, output int lat,
                           output int n_done, output int waits, output logic [127:0] ct);
    int remain;
    bit stalling;
    remain = stall_len; stalling = 0; lat = -1; n_done = 0; waits = 0; ct = '0;
    @(negedge clk);
    host_if.nk = nk; host_if.block_in = pt; host_if.start = 1'b1;
    @(posedge clk); #1;
    host_if.start = 1'b0; host_if.nk = 4'($urandom); host_if.block_in = {4{$urandom}};
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (host_if.done === 1'b1) begin
        n_done++;
        if (lat < 0) begin lat = i; ct = host_if.block_out; end
      end
      if (key_wait === 1'b1) waits++;
      host_if.start = (i == poke_at);
      if (i == poke_at) begin host_if.nk = 4'd3; host_if.block_in = {4{$urandom}}; end
      if (stalling) begin
        remain--;
        if (remain == 0) begin key_valid = 1'b1; stalling = 0; end
      end else if (remain > 0 && key_addr == 4'(stall_at) && host_if.busy) begin
        key_valid = 1'b0; stalling = 1;
      end
    end
    key_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_valid = 1'b1;
    host_if.start = 1'b0; host_if.nk = 4'd0; host_if.block_in = '0;
    for (int r = 0; r < 15; r++) rk[r] = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({host_if.busy, host_if.done, host_if.cfg_err, key_wait, key_addr, host_if.block_out} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got busy=%b done=%b cfg_err=%b key_wait=%b key_addr=%h block_out=%h, want all 0",
                         host_if.busy, host_if.done, host_if.cfg_err, key_wait, key_addr, host_if.block_out);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({host_if.busy, host_if.done, host_if.cfg_err, key_addr, host_if.block_out} !== '0) begin
      n_fail++; $display("FAIL idle_after_reset: got busy=%b done=%b cfg_err=%b key_addr=%h, want all 0",
                         host_if.busy, host_if.done, host_if.cfg_err, key_addr);
    end
  endtask

  task automatic test_known_vectors();
    logic [255:0] keys [3];
    logic [127:0] exp [3];
    logic [3:0]   codes [3];
    int lat, nd, w, nr;
    logic [127:0] ct;
    keys  = '{KEY128, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
              256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f};
    exp   = '{CT128, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 128'h8ea2b7ca516745bfeafc49904b496089};
    codes = '{4'd3, 4'd5, 4'd7};
    for (int k = 0; k < 3; k++) begin
      expand_key(keys[k], int'(codes[k]) + 1);
      nr = int'(codes[k]) + 7;
      run_block(codes[k], PT, -1, 0, -1, lat, nd, w, ct);
      n_checks++;
      if (ct !== exp[k]) begin n_fail++; $display("FAIL kat%0d_ct: got %h want %h", k, ct, exp[k]); end
      n_checks++;
      if (lat !== nr + 1) begin n_fail++; $display("FAIL kat%0d_latency: got %0d want %0d", k, lat, nr + 1); end
      n_checks++;
      if (nd !== 1) begin n_fail++; $display("FAIL kat%0d_done_pulses: got %0d want 1", k, nd); end
      n_checks++;
      if (host_if.block_out !== exp[k]) begin
        n_fail++; $display("FAIL kat%0d_hold: got %h want %h", k, host_if.block_out, exp[k]);
      end
    end
  endtask

  task automatic test_random_blocks();
    logic [3:0] codes [3];
    logic [3:0] code;
    logic [127:0] pt, ct, exp;
    int lat, nd, w, nr;
    codes = '{4'd3, 4'd5, 4'd7};
    for (int n = 0; n < 6; n++) begin
      code = codes[$urandom_range(0, 2)];
      nr = int'(code) + 7;
      expand_key({8{$urandom}}, int'(code) + 1);
      pt = {4{$urandom}};
      exp = ref_cipher(pt, nr);
      run_block(code, pt, -1, 0, -1, lat, nd, w, ct);
      n_checks++;
      if (ct !== exp) begin n_fail++; $display("FAIL rand%0d_ct nk=%0d: got %h want %h", n, code, ct, exp); end
      n_checks++;
      if (lat !== nr + 1 || nd !== 1) begin
        n_fail++; $display("FAIL rand%0d_timing: got lat=%0d dones=%0d want lat=%0d dones=1", n, lat, nd, nr + 1);
      end
    end
  endtask

  task automatic test_cfg_err();
    logic [3:0] bad [5];
    int ce, b, d;
    logic first;
    bad = '{4'd4, 4'd0, 4'd15, 4'd6, 4'd2};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      host_if.nk = bad[k]; host_if.block_in = {4{$urandom}}; host_if.start = 1'b1;
      @(posedge clk); #1;
      host_if.start = 1'b0;
      ce = 0; b = 0; d = 0; first = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (i == 0) first = host_if.cfg_err;
        ce += int'(host_if.cfg_err); b += int'(host_if.busy); d += int'(host_if.done);
      end
      n_checks++;
      if (first !== 1'b1 || ce !== 1) begin
        n_fail++; $display("FAIL cfg_err_pulse nk=%0d: got first=%b pulses=%0d want first=1 pulses=1", bad[k], first, ce);
      end
      n_checks++;
      if (b !== 0 || d !== 0) begin
        n_fail++; $display("FAIL cfg_err_quiet nk=%0d: got busy_cycles=%0d done_cycles=%0d want 0/0", bad[k], b, d);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int lat, nd, w;
    logic [127:0] ct;
    expand_key(KEY128, 4);
    run_block(4'd3, PT, -1, 0, 3, lat, nd, w, ct);
    n_checks++;
    if (ct !== CT128 || nd !== 1) begin
      n_fail++; $display("FAIL busy_start_ignored: got ct=%h dones=%0d want ct=%h dones=1", ct, nd, CT128);
    end
    n_checks++;
    if (lat !== 11) begin n_fail++; $display("FAIL busy_start_latency: got %0d want 11", lat); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] pts [3];
    logic [127:0] exp [3];
    int acc, k, prev;
    bit prev_busy;
    expand_key({8{$urandom}}, 6);
    for (int j = 0; j < 3; j++) begin pts[j] = {4{$urandom}}; exp[j] = ref_cipher(pts[j], 12); end
    @(negedge clk);
    host_if.nk = 4'd5; host_if.block_in = pts[0]; host_if.start = 1'b1;
    acc = 0; k = 0; prev = -1; prev_busy = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (host_if.busy === 1'b1 && !prev_busy) begin
        acc++;
        if (acc < 3) host_if.block_in = pts[acc];
        else host_if.start = 1'b0;
      end
      prev_busy = (host_if.busy === 1'b1);
      if (host_if.done === 1'b1) begin
        if (k < 3) begin
          n_checks++;
          if (host_if.block_out !== exp[k]) begin
            n_fail++; $display("FAIL b2b%0d_ct: got %h want %h", k, host_if.block_out, exp[k]);
          end
        end
        if (k > 0) begin
          n_checks++;
          if (i - prev !== 15) begin n_fail++; $display("FAIL b2b%0d_interval: got %0d want 15", k, i - prev); end
        end
        prev = i; k++;
      end
    end
    host_if.start = 1'b0;
    n_checks++;
    if (k !== 3) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 3", k); end
  endtask

  task automatic test_key_stall();
    int lat, nd, w, exp_w, exp_lat;
    logic [127:0] ct;
`ifdef AES_ENC_KEY_CHECK_EN
    exp_w = 3; exp_lat = 14;
`else
    exp_w = 0; exp_lat = 11;
`endif
    expand_key(KEY128, 4);
    run_block(4'd3, PT, 4, 3, -1, lat, nd, w, ct);
    n_checks++;
    if (ct !== CT128) begin n_fail++; $display("FAIL stall_ct: got %h want %h", ct, CT128); end
    n_checks++;
    if (w !== exp_w) begin n_fail++; $display("FAIL stall_key_wait: got %0d cycles want %0d", w, exp_w); end
    n_checks++;
    if (lat !== exp_lat || nd !== 1) begin
      n_fail++; $display("FAIL stall_latency: got lat=%0d dones=%0d want lat=%0d dones=1", lat, nd, exp_lat);
    end
  endtask

  task automatic test_reset_midway();
    bit found;
    int d, lat, nd, w;
    logic [127:0] ct;
    expand_key(KEY128, 4);
    @(negedge clk);
    host_if.nk = 4'd3; host_if.block_in = PT; host_if.start = 1'b1;
    @(posedge clk); #1;
    host_if.start = 1'b0;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (key_addr == 4'd5) found = 1;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL midrst_reach_round5: got key_addr=%h want 5", key_addr); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({host_if.busy, host_if.done, host_if.cfg_err, key_wait, key_addr, host_if.block_out} !== '0) begin
      n_fail++; $display("FAIL midrst_outputs: got busy=%b done=%b key_addr=%h block_out=%h, want all 0",
                         host_if.busy, host_if.done, key_addr, host_if.block_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    d = 0;
    repeat (16) begin @(negedge clk); d += int'(host_if.done); end
    n_checks++;
    if (d !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d done cycles want 0", d); end
    run_block(4'd3, PT, -1, 0, -1, lat, nd, w, ct);
    n_checks++;
    if (ct !== CT128 || lat !== 11) begin
      n_fail++; $display("FAIL midrst_restart: got ct=%h lat=%0d want ct=%h lat=11", ct, lat, CT128);
    end
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_random_blocks();
    test_cfg_err();
    test_start_while_busy();
    test_back_to_back();
    test_key_stall();
    test_reset_midway();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
